// File: rtl/usb_fs_nb_in_buf_pkg.sv
// Shared constants and helpers for the per-endpoint IN packet buffer.
package usb_fs_nb_in_buf_pkg;

  localparam int DefNumInEps         = 12;
  localparam int DefMaxInPktSizeByte = 32;

  // True when an index names an existing slot (index ports are wider than the slot count).
  function automatic logic idx_in_range(input logic [31:0] idx, input int limit);
    return idx < 32'(limit);
  endfunction

endpackage

// File: rtl/usb_fs_nb_in_buf.sv
// One committed IN packet per endpoint, served non-destructively to the PE by byte offset.
// Combinational read path; state updates one cycle after write/commit/ack/rollback/flush.
module usb_fs_nb_in_buf
  import usb_fs_nb_in_buf_pkg::*;
#(
  parameter int  NumInEps         = DefNumInEps,
  parameter int  MaxInPktSizeByte = DefMaxInPktSizeByte,
  localparam int PktW             = $clog2(MaxInPktSizeByte),
  localparam int InEpW            = $clog2(NumInEps)
) (
  input  logic                clk_48mhz_i,
  input  logic                rst_i,
  input  logic                link_reset_i,
  input  logic                wr_en_i,
  input  logic [InEpW-1:0]    wr_ep_i,
  input  logic [PktW-1:0]     wr_addr_i,
  input  logic [7:0]          wr_data_i,
  input  logic                commit_i,
  input  logic [InEpW-1:0]    commit_ep_i,
  input  logic [PktW:0]       commit_len_i,
  input  logic [NumInEps-1:0] flush_i,
  input  logic [3:0]          in_ep_current_i,
  input  logic [PktW-1:0]     in_ep_get_addr_i,
  input  logic                in_ep_data_get_i,
  input  logic                in_ep_newpkt_i,
  input  logic                in_ep_acked_i,
  input  logic                in_ep_rollback_i,
  input  logic [NumInEps-1:0] in_ep_iso_i,
  output logic [NumInEps-1:0] in_ep_has_data_o,
  output logic [NumInEps-1:0] in_ep_data_done_o,
  output logic [7:0]          in_ep_data_o,
  output logic [NumInEps-1:0] sent_o,
  output logic                wr_err_o
);

  localparam int            MemDepth = NumInEps * MaxInPktSizeByte;
  localparam int            MemAw    = InEpW + PktW;
  localparam logic [PktW:0] MaxLen   = (PktW+1)'(MaxInPktSizeByte);

  logic [7:0] mem_q [MemDepth];

  logic [NumInEps-1:0]           has_data_q, has_data_d;
  logic [NumInEps-1:0]           in_flight_q, in_flight_d;
  logic [NumInEps-1:0]           flush_pend_q, flush_pend_d;
  logic [NumInEps-1:0]           sent_q, sent_d;
  logic [NumInEps-1:0][PktW:0]   len_q, len_d;
  logic                          wr_err_q, wr_err_d;

  logic             wr_ok, commit_ok, cur_ok;
  logic [InEpW-1:0] cur_ep;
  logic [MemAw-1:0] wr_idx, rd_idx;
  logic             unused_data_get;

  // Byte-consumed strobe carries no information the offset does not already give.
  assign unused_data_get = in_ep_data_get_i;

  assign cur_ep = in_ep_current_i[InEpW-1:0];
  assign cur_ok = idx_in_range(32'(in_ep_current_i), NumInEps);
  assign wr_idx = {wr_ep_i, wr_addr_i};
  assign rd_idx = {cur_ep, in_ep_get_addr_i};

  assign wr_ok     = wr_en_i && idx_in_range(32'(wr_ep_i), NumInEps) && !has_data_q[wr_ep_i];
  assign commit_ok = commit_i && idx_in_range(32'(commit_ep_i), NumInEps)
                     && (commit_len_i <= MaxLen) && !has_data_q[commit_ep_i];
  assign wr_err_d  = (wr_en_i && !wr_ok) || (commit_i && !commit_ok);

  assign in_ep_data_o = cur_ok ? mem_q[rd_idx] : 8'h00;

  always_comb begin
    for (int i = 0; i < NumInEps; i++) begin
      in_ep_data_done_o[i] = ({1'b0, in_ep_get_addr_i} >= len_q[i]);
    end
  end

  always_comb begin
    logic sel, rel, rb, start;
    sel          = 1'b0;
    rel          = 1'b0;
    rb           = 1'b0;
    start        = 1'b0;
    has_data_d   = has_data_q;
    in_flight_d  = in_flight_q;
    flush_pend_d = flush_pend_q;
    len_d        = len_q;
    sent_d       = '0;
    for (int i = 0; i < NumInEps; i++) begin
      sel   = cur_ok && (cur_ep == InEpW'(i));
      rel   = sel && in_flight_q[i]
              && (in_ep_acked_i || (in_ep_iso_i[i] && in_ep_data_done_o[i]));
      rb    = sel && in_flight_q[i] && in_ep_rollback_i && !rel;
      start = sel && !in_flight_q[i] && in_ep_newpkt_i && has_data_q[i];
      if (rel) begin
        has_data_d[i]   = 1'b0;
        in_flight_d[i]  = 1'b0;
        flush_pend_d[i] = 1'b0;
        sent_d[i]       = 1'b1;
      end else if (rb) begin
        in_flight_d[i] = 1'b0;
        if (flush_pend_q[i] || flush_i[i]) begin
          has_data_d[i]   = 1'b0;
          flush_pend_d[i] = 1'b0;
        end
      end else begin
        if (start) in_flight_d[i] = 1'b1;
        // A flush never pulls data out from under a packet the PE has started.
        if (flush_i[i] && has_data_q[i]) begin
          if (in_flight_q[i] || start) flush_pend_d[i] = 1'b1;
          else                         has_data_d[i]   = 1'b0;
        end
      end
      if (commit_ok && (commit_ep_i == InEpW'(i))) begin
        has_data_d[i] = 1'b1;
        len_d[i]      = commit_len_i;
      end
    end
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (rst_i || link_reset_i) begin
      has_data_q   <= '0;
      in_flight_q  <= '0;
      flush_pend_q <= '0;
      sent_q       <= '0;
      len_q        <= '0;
      wr_err_q     <= 1'b0;
    end else begin
      has_data_q   <= has_data_d;
      in_flight_q  <= in_flight_d;
      flush_pend_q <= flush_pend_d;
      sent_q       <= sent_d;
      len_q        <= len_d;
      wr_err_q     <= wr_err_d;
    end
  end

  always_ff @(posedge clk_48mhz_i) begin
    if (wr_ok) mem_q[wr_idx] <= wr_data_i;
  end

  assign in_ep_has_data_o = has_data_q;
  assign sent_o           = sent_q;
  assign wr_err_o         = wr_err_q;

endmodule

// File: tb/tb_usb_fs_nb_in_buf.sv
// Directed and randomized checks of usb_fs_nb_in_buf against a slot-level behavioural model.
module tb_usb_fs_nb_in_buf;

  localparam int N = 12;
  localparam int M = 32;

  logic         clk_48mhz_i = 1'b0;
  logic         rst_i;
  logic         link_reset_i;
  logic         wr_en_i;
  logic [3:0]   wr_ep_i;
  logic [4:0]   wr_addr_i;
  logic [7:0]   wr_data_i;
  logic         commit_i;
  logic [3:0]   commit_ep_i;
  logic [5:0]   commit_len_i;
  logic [N-1:0] flush_i;
  logic [3:0]   in_ep_current_i;
  logic [4:0]   in_ep_get_addr_i;
  logic         in_ep_data_get_i;
  logic         in_ep_newpkt_i;
  logic         in_ep_acked_i;
  logic         in_ep_rollback_i;
  logic [N-1:0] in_ep_iso_i;
  logic [N-1:0] in_ep_has_data_o;
  logic [N-1:0] in_ep_data_done_o;
  logic [7:0]   in_ep_data_o;
  logic [N-1:0] sent_o;
  logic         wr_err_o;

  always #5 clk_48mhz_i = ~clk_48mhz_i;

  usb_fs_nb_in_buf dut (
    .clk_48mhz_i      (clk_48mhz_i),
    .rst_i            (rst_i),
    .link_reset_i     (link_reset_i),
    .wr_en_i          (wr_en_i),
    .wr_ep_i          (wr_ep_i),
    .wr_addr_i        (wr_addr_i),
    .wr_data_i        (wr_data_i),
    .commit_i         (commit_i),
    .commit_ep_i      (commit_ep_i),
    .commit_len_i     (commit_len_i),
    .flush_i          (flush_i),
    .in_ep_current_i  (in_ep_current_i),
    .in_ep_get_addr_i (in_ep_get_addr_i),
    .in_ep_data_get_i (in_ep_data_get_i),
    .in_ep_newpkt_i   (in_ep_newpkt_i),
    .in_ep_acked_i    (in_ep_acked_i),
    .in_ep_rollback_i (in_ep_rollback_i),
    .in_ep_iso_i      (in_ep_iso_i),
    .in_ep_has_data_o (in_ep_has_data_o),
    .in_ep_data_done_o(in_ep_data_done_o),
    .in_ep_data_o     (in_ep_data_o),
    .sent_o           (sent_o),
    .wr_err_o         (wr_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Slot-level model: what each endpoint holds and where its packet is in its life.
  logic [N-1:0] m_hd, m_fl, m_pend, m_sent;
  logic         m_err;
  int           m_len   [N];
  logic [7:0]   m_mem   [N][M];
  bit           m_known [N][M];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] exp_done;
    int c;
    exp_done = '0;
    for (int i = 0; i < N; i++) exp_done[i] = (int'(in_ep_get_addr_i) >= m_len[i]);
    check("has_data", 32'(in_ep_has_data_o), 32'(m_hd));
    check("sent", 32'(sent_o), 32'(m_sent));
    check("wr_err", 32'(wr_err_o), 32'(m_err));
    check("data_done", 32'(in_ep_data_done_o), 32'(exp_done));
    c = int'(in_ep_current_i);
    if (c >= N) check("data_bad_ep", 32'(in_ep_data_o), 32'h0);
    else if (m_known[c][in_ep_get_addr_i]) check("data", 32'(in_ep_data_o), 32'(m_mem[c][in_ep_get_addr_i]));
  endtask

  task automatic model_update();
    logic [N-1:0] nhd, nfl, npend, nsent, closed;
    int nlen [N];
    logic nerr;
    int c, we, ce;
    nhd = m_hd; nfl = m_fl; npend = m_pend; nsent = '0; closed = '0; nerr = 1'b0;
    for (int i = 0; i < N; i++) nlen[i] = m_len[i];
    if (rst_i) begin
      m_hd = '0; m_fl = '0; m_pend = '0; m_sent = '0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_len[i] = 0;
      return;
    end
    we = int'(wr_ep_i);
    if (wr_en_i) begin
      if (we < N && !m_hd[we]) begin
        m_mem[we][wr_addr_i]   = wr_data_i;
        m_known[we][wr_addr_i] = 1'b1;
      end else nerr = 1'b1;
    end
    ce = int'(commit_ep_i);
    if (commit_i) begin
      if (ce < N && int'(commit_len_i) <= M && !m_hd[ce]) begin
        nhd[ce]  = 1'b1;
        nlen[ce] = int'(commit_len_i);
      end else nerr = 1'b1;
    end
    c = int'(in_ep_current_i);
    if (c < N) begin
      if (m_fl[c] && (in_ep_acked_i || (in_ep_iso_i[c] && int'(in_ep_get_addr_i) >= m_len[c]))) begin
        nhd[c] = 1'b0; nfl[c] = 1'b0; npend[c] = 1'b0; nsent[c] = 1'b1; closed[c] = 1'b1;
      end else if (m_fl[c] && in_ep_rollback_i) begin
        nfl[c] = 1'b0; closed[c] = 1'b1;
        if (m_pend[c] || flush_i[c]) begin
          nhd[c] = 1'b0; npend[c] = 1'b0;
        end
      end else if (!m_fl[c] && in_ep_newpkt_i && m_hd[c]) nfl[c] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (!closed[i] && flush_i[i] && m_hd[i]) begin
        if (nfl[i]) npend[i] = 1'b1;
        else        nhd[i]   = 1'b0;
      end
    end
    if (link_reset_i) begin
      nhd = '0; nfl = '0; npend = '0; nsent = '0; nerr = 1'b0;
      for (int i = 0; i < N; i++) nlen[i] = 0;
    end
    m_hd = nhd; m_fl = nfl; m_pend = npend; m_sent = nsent; m_err = nerr;
    for (int i = 0; i < N; i++) m_len[i] = nlen[i];
  endtask

  // Inputs are driven just after the falling edge; checks land before the rising edge.
  task automatic step();
    #2;
    if (chk_en) compare_model();
    @(posedge clk_48mhz_i);
    model_update();
    @(negedge clk_48mhz_i);
  endtask

  task automatic idle();
    wr_en_i = 1'b0; commit_i = 1'b0; flush_i = '0; in_ep_newpkt_i = 1'b0;
    in_ep_acked_i = 1'b0; in_ep_rollback_i = 1'b0; link_reset_i = 1'b0; in_ep_data_get_i = 1'b0;
  endtask

  task automatic do_commit(input int ep, input int len);
    idle();
    commit_i = 1'b1; commit_ep_i = 4'(ep); commit_len_i = 6'(len);
    step();
    idle();
  endtask

  task automatic write_bytes(input int ep, input logic [7:0] base, input int cnt);
    for (int a = 0; a < cnt; a++) begin
      idle();
      wr_en_i = 1'b1; wr_ep_i = 4'(ep); wr_addr_i = 5'(a); wr_data_i = base + 8'(a);
      step();
    end
    idle();
  endtask

  task automatic read_ep2_bytes(input string tag);
    in_ep_current_i = 4'd2;
    for (int a = 0; a < 8; a++) begin
      in_ep_get_addr_i = 5'(a);
      #1;
      check(tag, 32'(in_ep_data_o), 32'h10 + 32'(a));
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1; idle();
    wr_ep_i = '0; wr_addr_i = '0; wr_data_i = '0; commit_ep_i = '0; commit_len_i = '0;
    in_ep_current_i = '0; in_ep_get_addr_i = '0; in_ep_iso_i = '0;
    for (int i = 0; i < N; i++) for (int a = 0; a < M; a++) m_known[i][a] = 1'b0;
    repeat (3) step();
    rst_i = 1'b0; chk_en = 1'b1;
    #1;
    check("reset_has_data", 32'(in_ep_has_data_o), 32'h0);
    check("reset_sent", 32'(sent_o), 32'h0);
    check("reset_wr_err", 32'(wr_err_o), 32'h0);
    check("reset_done_addr0", 32'(in_ep_data_done_o), 32'hfff);
    step();

    write_bytes(2, 8'h10, 8);
    do_commit(2, 8);
    #1; check("commit_ep2_has_data", 32'(in_ep_has_data_o), 32'h004);
    in_ep_current_i = 4'd2;
    for (int a = 0; a <= 8; a++) begin
      in_ep_get_addr_i = 5'(a);
      #1;
      if (a < 8) check("ep2_byte", 32'(in_ep_data_o), 32'h10 + 32'(a));
      check("ep2_done", 32'(in_ep_data_done_o[2]), (a >= 8) ? 32'h1 : 32'h0);
      step();
    end

    in_ep_get_addr_i = 5'd0;
    in_ep_newpkt_i = 1'b1; step(); idle();
    in_ep_acked_i = 1'b1; step(); idle();
    #1;
    check("ack_sent_pulse", 32'(sent_o), 32'h004);
    check("ack_has_data", 32'(in_ep_has_data_o), 32'h0);
    step();
    #1; check("ack_sent_one_cycle", 32'(sent_o), 32'h0);
    do_commit(2, 8);
    #1;
    check("recommit_has_data", 32'(in_ep_has_data_o), 32'h004);
    check("recommit_no_err", 32'(wr_err_o), 32'h0);

    in_ep_current_i = 4'd2; in_ep_newpkt_i = 1'b1; step(); idle();
    in_ep_rollback_i = 1'b1; step(); idle();
    #1; check("rollback_has_data", 32'(in_ep_has_data_o), 32'h004);
    read_ep2_bytes("rollback_resend_byte");

    do_commit(3, 4);
    do_commit(3, 9);
    #1; check("commit_busy_err", 32'(wr_err_o), 32'h1);
    in_ep_current_i = 4'd3; in_ep_get_addr_i = 5'd4;
    #1; check("busy_len_kept_done4", 32'(in_ep_data_done_o[3]), 32'h1);
    in_ep_get_addr_i = 5'd3;
    #1; check("busy_len_kept_done3", 32'(in_ep_data_done_o[3]), 32'h0);
    step();
    do_commit(4, 33);
    #1;
    check("len33_err", 32'(wr_err_o), 32'h1);
    check("len33_no_data", 32'(in_ep_has_data_o[4]), 32'h0);
    step();
    #1; check("err_one_cycle", 32'(wr_err_o), 32'h0);

    write_bytes(5, 8'hA0, 4);
    do_commit(5, 4);
    in_ep_iso_i = 12'h020; in_ep_current_i = 4'd5; in_ep_get_addr_i = 5'd0;
    in_ep_newpkt_i = 1'b1; step(); idle();
    for (int a = 0; a < 4; a++) begin
      in_ep_get_addr_i = 5'(a);
      #1;
      check("iso_byte", 32'(in_ep_data_o), 32'hA0 + 32'(a));
      check("iso_hold", 32'(in_ep_has_data_o[5]), 32'h1);
      step();
    end
    in_ep_get_addr_i = 5'd4; step();
    #1;
    check("iso_sent", 32'(sent_o), 32'h020);
    check("iso_released", 32'(in_ep_has_data_o[5]), 32'h0);
    in_ep_iso_i = '0; in_ep_get_addr_i = 5'd0;
    step();

    in_ep_current_i = 4'd2; in_ep_newpkt_i = 1'b1; step(); idle();
    flush_i = 12'h004; step(); idle();
    #1; check("flush_inflight_hold", 32'(in_ep_has_data_o[2]), 32'h1);
    step();
    in_ep_rollback_i = 1'b1; step(); idle();
    #1;
    check("flush_on_rollback", 32'(in_ep_has_data_o[2]), 32'h0);
    check("flush_no_sent", 32'(sent_o), 32'h0);

    do_commit(2, 8);
    in_ep_current_i = 4'd3; in_ep_newpkt_i = 1'b1; step(); idle();
    link_reset_i = 1'b1; in_ep_acked_i = 1'b1; commit_i = 1'b1; commit_ep_i = 4'd6; commit_len_i = 6'd2;
    step(); idle();
    #1;
    check("link_reset_has_data", 32'(in_ep_has_data_o), 32'h0);
    check("link_reset_sent", 32'(sent_o), 32'h0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle();
      if (cyc % 250 == 0) in_ep_iso_i = N'($urandom);
      wr_en_i      = ($urandom_range(0, 1) == 0);
      wr_ep_i      = 4'($urandom_range(0, 13));
      wr_addr_i    = 5'($urandom);
      wr_data_i    = 8'($urandom);
      commit_i     = ($urandom_range(0, 9) == 0);
      commit_ep_i  = 4'($urandom_range(0, 13));
      commit_len_i = 6'($urandom_range(0, 34));
      if ($urandom_range(0, 19) == 0) flush_i = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 7) == 0) in_ep_current_i = 4'($urandom_range(0, 13));
      in_ep_get_addr_i = 5'($urandom);
      in_ep_data_get_i = ($urandom_range(0, 1) == 0);
      in_ep_newpkt_i   = ($urandom_range(0, 5) == 0);
      in_ep_acked_i    = ($urandom_range(0, 7) == 0);
      in_ep_rollback_i = ($urandom_range(0, 15) == 0);
      link_reset_i     = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
